// File: rtl/sig_cfg_ctrl.sv
// Signal-generator front panel: three debounced buttons drive a small
// EDIT / ARM / RUN controller that edits four 2-bit parameter fields and
// gates the generator enable.
module sig_cfg_ctrl #(
    parameter int unsigned DEB_CNT = 1000000,
    parameter int unsigned SETTLE  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_sel_n,
    input  logic       key_inc_n,
    input  logic       key_ok_n,
    output logic [1:0] cnt_sig,
    output logic [1:0] cnt_amp,
    output logic [1:0] cnt_fre,
    output logic [1:0] cnt_phase,
    output logic       confirm,
    output logic [1:0] menu,
    output logic [1:0] state_o
);

    localparam int unsigned CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] DEB_MAX    = CW'(DEB_CNT - 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE - 1);

    // key index: 0 = sel, 1 = inc, 2 = ok
    localparam int unsigned K_SEL = 0;
    localparam int unsigned K_INC = 1;
    localparam int unsigned K_OK  = 2;

    typedef enum logic [1:0] {
        EDIT = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    logic [2:0]    keys_raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    last;
    logic [2:0]    deb;
    logic [2:0]    armed;
    logic [2:0]    ev;
    logic [1:0]    sync_vld;
    logic [CW-1:0] deb_cnt [3];

    state_t        state_q, state_d;
    logic [1:0]    menu_q, menu_d;
    logic [1:0]    field_q [4];
    logic [1:0]    field_d [4];
    logic [SW-1:0] settle_q, settle_d;
    logic          confirm_q, confirm_d;

    assign keys_raw = {key_ok_n, key_inc_n, key_sel_n};

    // Synchronise, debounce and edge-detect each key. A key only produces
    // press events once it has been seen stably released since reset
    // (armed), so a button held through reset stays silent until re-pressed.
    // sync_vld keeps the counters idle until the synchroniser holds real data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1    <= '1;
            sync2    <= '1;
            last     <= '1;
            deb      <= '1;
            armed    <= '0;
            ev       <= '0;
            sync_vld <= '0;
            for (int unsigned k = 0; k < 3; k++) begin
                deb_cnt[k] <= '0;
            end
        end else begin
            sync1    <= keys_raw;
            sync2    <= sync1;
            sync_vld <= {sync_vld[0], 1'b1};
            for (int unsigned k = 0; k < 3; k++) begin
                last[k] <= sync2[k];
                ev[k]   <= 1'b0;
                if (!sync_vld[1] || (sync2[k] != last[k])) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DEB_MAX) begin
                    deb[k] <= sync2[k];
                    if (sync2[k]) begin
                        armed[k] <= 1'b1;
                    end
                    ev[k] <= armed[k] & deb[k] & ~sync2[k];
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + 1'b1;
                end
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EDIT;
            menu_q     <= 2'd0;
            field_q[0] <= 2'd0;
            field_q[1] <= 2'd1;
            field_q[2] <= 2'd0;
            field_q[3] <= 2'd0;
            settle_q   <= '0;
            confirm_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            menu_q    <= menu_d;
            field_q   <= field_d;
            settle_q  <= settle_d;
            confirm_q <= confirm_d;
        end
    end

    // Next-state: ok has top priority in EDIT and RUN; ARM times out on settle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EDIT: if (ev[K_OK]) state_d = ARM;
            ARM:  if (settle_q == SETTLE_MAX) state_d = RUN;
            RUN:  if (ev[K_OK]) state_d = EDIT;
            default: state_d = EDIT;
        endcase
    end

    // Next outputs: field edits happen only in EDIT, ok > sel > inc.
    always_comb begin
        menu_d    = menu_q;
        field_d   = field_q;
        settle_d  = settle_q;
        confirm_d = (state_d == RUN);
        case (state_q)
            EDIT: begin
                if (ev[K_OK]) begin
                    settle_d = '0;
                end else if (ev[K_SEL]) begin
                    menu_d = menu_q + 2'd1;
                end else if (ev[K_INC]) begin
                    field_d[menu_q] = field_q[menu_q] + 2'd1;
                end
            end
            ARM: begin
                settle_d = settle_q + 1'b1;
            end
            RUN: begin
            end
            default: begin
                confirm_d = 1'b0;
            end
        endcase
    end

    assign cnt_sig   = field_q[0];
    assign cnt_amp   = field_q[1];
    assign cnt_fre   = field_q[2];
    assign cnt_phase = field_q[3];
    assign menu      = menu_q;
    assign confirm   = confirm_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_sig_cfg_ctrl.sv
// Directed bench for sig_cfg_ctrl with short debounce and settle times.
module tb_sig_cfg_ctrl;

    logic       clk;
    logic       rst_n;
    logic       key_sel_n;
    logic       key_inc_n;
    logic       key_ok_n;
    logic [1:0] cnt_sig;
    logic [1:0] cnt_amp;
    logic [1:0] cnt_fre;
    logic [1:0] cnt_phase;
    logic       confirm;
    logic [1:0] menu;
    logic [1:0] state_o;

    int n_checks = 0;
    int n_pass   = 0;

    sig_cfg_ctrl #(
        .DEB_CNT(4),
        .SETTLE (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_sel_n(key_sel_n),
        .key_inc_n(key_inc_n),
        .key_ok_n (key_ok_n),
        .cnt_sig  (cnt_sig),
        .cnt_amp  (cnt_amp),
        .cnt_fre  (cnt_fre),
        .cnt_phase(cnt_phase),
        .confirm  (confirm),
        .menu     (menu),
        .state_o  (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // press and release one key (0 sel, 1 inc, 2 ok), long enough to debounce both edges
    task automatic press(input int k);
        if (k == 0) key_sel_n = 1'b0;
        if (k == 1) key_inc_n = 1'b0;
        if (k == 2) key_ok_n  = 1'b0;
        cycles(12);
        key_sel_n = 1'b1;
        key_inc_n = 1'b1;
        key_ok_n  = 1'b1;
        cycles(12);
    endtask

    initial begin
        int lat;
        int arm_cycles;
        logic conf_bad;
        logic seen;

        rst_n = 1'b0;
        key_sel_n = 1'b1;
        key_inc_n = 1'b1;
        key_ok_n  = 1'b1;
        @(negedge clk);
        cycles(2);
        check("rst_state", state_o, 0);
        check("rst_confirm", confirm, 0);
        check("rst_sig", cnt_sig, 0);
        check("rst_amp", cnt_amp, 1);
        check("rst_fre", cnt_fre, 0);
        check("rst_phase", cnt_phase, 0);
        check("rst_menu", menu, 0);
        rst_n = 1'b1;
        cycles(10);

        // bounce on inc, then hold low
        for (int i = 0; i < 10; i++) begin
            key_inc_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            cycles(2);
        end
        key_inc_n = 1'b0;
        check("bounce_no_event", cnt_sig, 0);
        lat = 0;
        seen = 1'b0;
        for (int i = 1; i <= 30 && !seen; i++) begin
            cycles(1);
            if (cnt_sig != 2'd0) begin
                seen = 1'b1;
                lat = i;
            end
        end
        check("bounce_event_seen", seen, 1);
        check("bounce_latency_ok", (lat >= 4 && lat <= 10), 1);
        cycles(20);
        check("bounce_single_event", cnt_sig, 1);
        key_inc_n = 1'b1;
        cycles(12);

        // menu and field wrap
        for (int i = 0; i < 3; i++) press(0);
        check("menu_3", menu, 3);
        for (int i = 0; i < 5; i++) press(1);
        check("phase_wrap", cnt_phase, 1);
        check("sig_kept", cnt_sig, 1);
        check("amp_kept", cnt_amp, 1);
        press(0);
        check("menu_wrap", menu, 0);

        // arm and run
        key_ok_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cycles(1);
            if (state_o != 2'd0) seen = 1'b1;
        end
        check("arm_entered", state_o, 1);
        arm_cycles = 0;
        conf_bad = 1'b0;
        for (int i = 0; i < 20 && state_o == 2'd1; i++) begin
            arm_cycles++;
            if (confirm) conf_bad = 1'b1;
            cycles(1);
        end
        check("arm_len", arm_cycles, 4);
        check("arm_confirm_low", conf_bad, 0);
        check("run_state", state_o, 2);
        check("run_confirm", confirm, 1);
        key_ok_n = 1'b1;
        cycles(12);
        press(1);
        check("run_inc_ignored", cnt_sig, 1);
        check("run_still", state_o, 2);
        key_ok_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cycles(1);
            if (state_o != 2'd2) seen = 1'b1;
        end
        check("stop_state", state_o, 0);
        check("stop_confirm", confirm, 0);
        key_ok_n = 1'b1;
        cycles(12);

        // simultaneous keys
        key_sel_n = 1'b0;
        key_inc_n = 1'b0;
        cycles(12);
        key_sel_n = 1'b1;
        key_inc_n = 1'b1;
        cycles(12);
        check("simul_menu", menu, 1);
        check("simul_sig", cnt_sig, 1);
        check("simul_amp", cnt_amp, 1);
        key_ok_n  = 1'b0;
        key_inc_n = 1'b0;
        cycles(24);
        key_inc_n = 1'b1;
        cycles(12);
        check("okinc_state", state_o, 2);
        check("okinc_amp", cnt_amp, 1);
        check("okinc_menu", menu, 1);

        // reset in RUN with ok still held
        rst_n = 1'b0;
        cycles(1);
        check("rrst_confirm", confirm, 0);
        check("rrst_state", state_o, 0);
        check("rrst_sig", cnt_sig, 0);
        check("rrst_menu", menu, 0);
        rst_n = 1'b1;
        cycles(30);
        check("held_no_event", state_o, 0);
        key_ok_n = 1'b1;
        cycles(12);
        key_ok_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cycles(1);
            if (state_o != 2'd0) seen = 1'b1;
        end
        check("repress_arm", state_o, 1);
        key_ok_n = 1'b1;
        cycles(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
